// File: rtl/o_upd_pkg.sv
// Shared types and arithmetic helpers for the output rescale-coefficient sequencer.
package o_upd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ITER,
      S_WRITE,
      S_DONE
   } o_upd_state_t;

   localparam logic MODE_RESCALE = 1'b0;
   localparam logic MODE_NORM    = 1'b1;

   // log2(e) in Q.13, used to turn exp(d) into 2^(d*log2e)
   localparam logic [63:0] LOG2E_Q13 = 64'd11819;

   function automatic logic signed [63:0] sat_shift(input logic signed [63:0] prod,
                                                    input int frac_bit,
                                                    input int d_w);
      logic signed [63:0] sh;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sh = prod >>> frac_bit;
      hi = (64'sd1 <<< (d_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (sh > hi) return hi;
      if (sh < lo) return lo;
      return sh;
   endfunction

   // exp(d) for d <= 0: t = -d*log2e, split into integer n and fraction f,
   // 2^-f approximated linearly as 1 - f/2, then shifted right by n.
   function automatic logic [31:0] safe_softmax_exp(input logic signed [31:0] d,
                                                    input int frac_bit);
      logic [31:0] nd;
      logic [31:0] t;
      logic [31:0] n;
      logic [31:0] f;
      logic [31:0] one;
      nd  = (d < 0) ? 32'(-d) : 32'd0;
      t   = 32'(({32'd0, nd} * LOG2E_Q13) >> 13);
      n   = t >> frac_bit;
      one = 32'd1 << frac_bit;
      f   = t & (one - 32'd1);
      if (n > 32'd31) return 32'd0;
      return (one - (f >> 1)) >> n;
   endfunction

endpackage

// File: rtl/coef_div_seq.sv
// Single-lane restoring divider: quotient = (dividend << FRAC_BIT) / divisor,
// one bit per cycle, saturating on divide-by-zero or quotient overflow.
module coef_div_seq #(
   parameter int D_W      = 16,
   parameter int FRAC_BIT = 13
) (
   input  logic           clk_sys,
   input  logic           rst_b,
   input  logic           start,
   input  logic [D_W-1:0] dividend,
   input  logic [D_W-1:0] divisor,
   output logic           busy,
   output logic           done,
   output logic [D_W-1:0] quotient
);

   localparam int NW  = 2 * D_W;
   localparam int NW1 = NW + 1;
   localparam int CW  = $clog2(D_W + 1);
   localparam logic [D_W-1:0] Q_MAX = {1'b0, {(D_W-1){1'b1}}};

   logic [NW-1:0]  acc;
   logic [D_W-1:0] dvs;
   logic [CW-1:0]  cnt;
   logic           sat_q;
   logic           done_q;
   logic [NW-1:0]  num;
   logic [D_W:0]   trial;
   logic           ovf;

   // Overflow iff num >= divisor * 2^(D_W-1); otherwise the upper half of num
   // is already below the divisor and D_W steps yield the exact quotient.
   always_comb begin
      num   = NW'(dividend) << FRAC_BIT;
      ovf   = (divisor == '0) || ({1'b0, num} >= (NW1'(divisor) << (D_W - 1)));
      trial = {acc[NW-1:D_W], acc[D_W-1]};
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         acc    <= '0;
         dvs    <= '0;
         cnt    <= '0;
         sat_q  <= 1'b0;
         done_q <= 1'b0;
      end else if (start) begin
         acc    <= num;
         dvs    <= divisor;
         cnt    <= CW'(D_W);
         sat_q  <= ovf;
         done_q <= 1'b0;
      end else if (cnt != '0) begin
         if (trial >= {1'b0, dvs})
            acc <= {D_W'(trial - {1'b0, dvs}), acc[D_W-2:0], 1'b1};
         else
            acc <= {trial[D_W-1:0], acc[D_W-2:0], 1'b0};
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) done_q <= 1'b1;
      end
   end

   assign busy     = (cnt != '0);
   assign done     = done_q;
   assign quotient = sat_q ? Q_MAX : acc[D_W-1:0];

endmodule

// File: rtl/o_coef_upd_seq.sv
// Per-row O rescale / normalise coefficient sequencer with LANES time-shared dividers.
//
//  state   | meaning
//  IDLE    | ready for a tile, inputs latched on accept
//  LOAD    | start dividers for group g
//  ITER    | D_W divider steps
//  WRITE   | exp * quotient, write group g coefficients
//  DONE    | hold outputs until downstream accepts
module o_coef_upd_seq
   import o_upd_pkg::*;
#(
   parameter int D_W      = 16,
   parameter int FRAC_BIT = 13,
   parameter int TIL      = 16,
   parameter int LANES    = 4
) (
   input  logic           I_CLK,
   input  logic           I_RST_N,
   input  logic           I_VLD,
   output logic           O_RDY,
   input  logic           I_MODE,
   input  logic [D_W-1:0] I_LI_OLD [0:TIL-1],
   input  logic [D_W-1:0] I_MI_OLD [0:TIL-1],
   input  logic [D_W-1:0] I_LI_NEW [0:TIL-1],
   input  logic [D_W-1:0] I_MI_NEW [0:TIL-1],
   output logic           O_VLD,
   input  logic           I_RDY,
   output logic [D_W-1:0] O_COEFFICIENT [0:TIL-1],
   output logic           O_BUSY
);

   localparam int G   = TIL / LANES;
   localparam int G_W = (G > 1) ? $clog2(G) : 1;
   localparam int R_W = (TIL > 1) ? $clog2(TIL) : 1;
   localparam int I_W = $clog2(D_W);
   localparam logic [D_W-1:0] ONE = D_W'(1) << FRAC_BIT;

   if (TIL % LANES != 0) begin : g_bad_cfg
      $error("TIL must be a multiple of LANES");
   end

   o_upd_state_t   state;
   logic [G_W-1:0] g;
   logic [I_W-1:0] it_cnt;
   logic           mode_q;
   logic           o_vld_q;
   logic           busy_q;
   logic           accept;
   logic           sign_unused;

   logic [D_W-2:0] l_old_q [TIL];
   logic [D_W-2:0] l_new_q [TIL];
   logic [D_W-1:0] m_old_q [TIL];
   logic [D_W-1:0] m_new_q [TIL];
   logic [D_W-1:0] coef_q  [TIL];

   logic [LANES-1:0] lane_busy;
   logic [LANES-1:0] lane_done;
   logic [R_W-1:0]   row_idx   [LANES];
   logic [D_W-1:0]   lane_coef [LANES];

   assign O_RDY  = I_RST_N && (state == S_IDLE);
   assign accept = I_VLD && O_RDY;

   // Sums are magnitudes: their sign bits never reach the datapath.
   always_comb begin
      sign_unused = 1'b0;
      for (int i = 0; i < TIL; i++)
         sign_unused = sign_unused ^ I_LI_OLD[i][D_W-1] ^ I_LI_NEW[i][D_W-1];
   end

   always_ff @(posedge I_CLK) begin
      if (accept) begin
         for (int i = 0; i < TIL; i++) begin
            l_old_q[i] <= I_LI_OLD[i][D_W-2:0];
            l_new_q[i] <= I_LI_NEW[i][D_W-2:0];
            m_old_q[i] <= I_MI_OLD[i];
            m_new_q[i] <= I_MI_NEW[i];
         end
      end
   end

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [R_W-1:0]          row;
      logic [D_W-1:0]          dvd;
      logic [D_W-1:0]          dvs;
      logic [D_W-1:0]          q;
      logic signed [D_W-1:0]   d_raw;
      logic signed [D_W-1:0]   d_cl;
      logic signed [D_W-1:0]   exp_v;
      logic signed [2*D_W-1:0] prod;

      assign row = R_W'(32'(g) * 32'(LANES) + 32'(j));
      assign dvd = (mode_q == MODE_RESCALE) ? {1'b0, l_old_q[row]} : ONE;
      assign dvs = {1'b0, l_new_q[row]};

      coef_div_seq #(
         .D_W      (D_W),
         .FRAC_BIT (FRAC_BIT)
      ) u_div (
         .clk_sys  (I_CLK),
         .rst_b    (I_RST_N),
         .start    (state == S_LOAD),
         .dividend (dvd),
         .divisor  (dvs),
         .busy     (lane_busy[j]),
         .done     (lane_done[j]),
         .quotient (q)
      );

      // A rising max (d > 0) is illegal upstream; treat it as no rescale.
      assign d_raw = m_old_q[row] - m_new_q[row];
      assign d_cl  = d_raw[D_W-1] ? d_raw : '0;
      assign exp_v = (mode_q == MODE_NORM) ? ONE
                                           : D_W'(safe_softmax_exp(32'(d_cl), FRAC_BIT));
      assign prod  = exp_v * $signed(q);

      assign row_idx[j]   = row;
      assign lane_coef[j] = D_W'(sat_shift(64'(prod), FRAC_BIT, D_W));
   end

   always_ff @(posedge I_CLK) begin
      if (!I_RST_N) begin
         state   <= S_IDLE;
         g       <= '0;
         it_cnt  <= '0;
         mode_q  <= MODE_RESCALE;
         o_vld_q <= 1'b0;
         busy_q  <= 1'b0;
         for (int i = 0; i < TIL; i++) coef_q[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  mode_q <= I_MODE;
                  g      <= '0;
                  busy_q <= 1'b1;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               it_cnt <= I_W'(D_W - 1);
               state  <= S_ITER;
            end
            S_ITER: begin
               if (it_cnt == '0) state <= S_WRITE;
               else              it_cnt <= it_cnt - I_W'(1);
            end
            S_WRITE: begin
               if ((&lane_done) && !(|lane_busy)) begin
                  for (int j = 0; j < LANES; j++) coef_q[row_idx[j]] <= lane_coef[j];
               end
               if (g == G_W'(G - 1)) begin
                  state <= S_DONE;
               end else begin
                  g     <= g + G_W'(1);
                  state <= S_LOAD;
               end
            end
            S_DONE: begin
               if (o_vld_q && I_RDY) begin
                  o_vld_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  o_vld_q <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign O_VLD         = o_vld_q;
   assign O_BUSY        = busy_q;
   assign O_COEFFICIENT = coef_q;

endmodule

// File: tb/tb_o_coef_upd_seq.sv
// Self-checking bench for o_coef_upd_seq: directed corner tiles plus random tiles
// against an arithmetic reference model.
module tb_o_coef_upd_seq;

   localparam int D_W      = 16;
   localparam int FRAC_BIT = 13;
   localparam int TIL      = 16;
   localparam int LANES    = 4;
   localparam int G        = TIL / LANES;
   localparam int LAT      = G * (D_W + 2) + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic vld   = 1'b0;
   logic mode  = 1'b0;
   logic rdy   = 1'b0;
   logic o_rdy;
   logic o_vld;
   logic o_busy;
   logic [D_W-1:0] li_old [0:TIL-1];
   logic [D_W-1:0] mi_old [0:TIL-1];
   logic [D_W-1:0] li_new [0:TIL-1];
   logic [D_W-1:0] mi_new [0:TIL-1];
   logic [D_W-1:0] coef   [0:TIL-1];

   int tests = 0;
   int fails = 0;

   logic [15:0] t_lo [TIL];
   logic [15:0] t_ln [TIL];
   logic [15:0] t_mo [TIL];
   logic [15:0] t_mn [TIL];
   logic [15:0] exp_c [TIL];
   bit          t_mode;

   always #5 clk = ~clk;

   o_coef_upd_seq #(
      .D_W      (D_W),
      .FRAC_BIT (FRAC_BIT),
      .TIL      (TIL),
      .LANES    (LANES)
   ) dut (
      .I_CLK         (clk),
      .I_RST_N       (rst_n),
      .I_VLD         (vld),
      .O_RDY         (o_rdy),
      .I_MODE        (mode),
      .I_LI_OLD      (li_old),
      .I_MI_OLD      (mi_old),
      .I_LI_NEW      (li_new),
      .I_MI_NEW      (mi_new),
      .O_VLD         (o_vld),
      .I_RDY         (rdy),
      .O_COEFFICIENT (coef),
      .O_BUSY        (o_busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // exp(d), d<=0: 2^-(n+f) with 2^-f ~ 1 - f/2, t = -d*log2e in Q.13
   function automatic int exp_ref(int d);
      longint t;
      int     n;
      int     f;
      if (d > 0) d = 0;
      t = (longint'(-d) * 11819) / 8192;
      n = int'(t / 8192);
      f = int'(t % 8192);
      if (n > 30) return 0;
      return (8192 - f / 2) / (1 << n);
   endfunction

   function automatic logic [15:0] ref_coef(bit md, logic [15:0] lo, logic [15:0] ln,
                                            logic [15:0] mo, logic [15:0] mn);
      longint             q;
      longint             p;
      int                 dvd;
      int                 dvs;
      int                 e;
      logic signed [15:0] d16;
      dvd = md ? 8192 : int'(lo[14:0]);
      dvs = int'(ln[14:0]);
      q   = (dvs == 0) ? 64'd32767 : (longint'(dvd) * 8192) / dvs;
      if (q > 32767) q = 32767;
      d16 = mo - mn;
      e   = md ? 8192 : exp_ref(int'(d16));
      p   = (longint'(e) * q) / 8192;
      if (p > 32767) p = 32767;
      return p[15:0];
   endfunction

   task automatic set_all(input logic [15:0] lo, input logic [15:0] ln,
                          input logic [15:0] mo, input logic [15:0] mn);
      for (int i = 0; i < TIL; i++) begin
         t_lo[i] = lo;
         t_ln[i] = ln;
         t_mo[i] = mo;
         t_mn[i] = mn;
      end
   endtask

   task automatic rand_tile;
      int lo_m;
      int ln_m;
      t_mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < TIL; i++) begin
         lo_m = $urandom_range(1, 32767);
         ln_m = ($urandom_range(0, 3) != 0) ? $urandom_range(lo_m / 3 + 1, 32767)
                                             : $urandom_range(1, 32767);
         t_lo[i] = {1'($urandom_range(0, 1)), 15'(lo_m)};
         t_ln[i] = {1'($urandom_range(0, 1)), 15'(ln_m)};
         t_mn[i] = 16'($urandom_range(0, 16'h2000));
         if ($urandom_range(0, 7) == 0) t_mo[i] = t_mn[i] + 16'($urandom_range(1, 100));
         else                           t_mo[i] = t_mn[i] - 16'($urandom_range(0, 16'h5000));
      end
   endtask

   task automatic start_tile(input string tag);
      for (int i = 0; i < TIL; i++)
         exp_c[i] = ref_coef(t_mode, t_lo[i], t_ln[i], t_mo[i], t_mn[i]);
      chk({tag, " ready before accept"}, 32'(o_rdy), 32'd1);
      for (int i = 0; i < TIL; i++) begin
         li_old[i] = t_lo[i];
         li_new[i] = t_ln[i];
         mi_old[i] = t_mo[i];
         mi_new[i] = t_mn[i];
      end
      mode = t_mode;
      vld  = 1'b1;
      tick;
      vld  = 1'b0;
      mode = ~t_mode;
      for (int i = 0; i < TIL; i++) begin
         li_old[i] = 16'($urandom);
         li_new[i] = 16'($urandom);
         mi_old[i] = 16'($urandom);
         mi_new[i] = 16'($urandom);
      end
   endtask

   task automatic wait_out(input string tag);
      int n;
      n = 0;
      while (o_vld !== 1'b1 && n < 300) begin
         tick;
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(LAT));
   endtask

   task automatic check_coefs(input string tag);
      for (int i = 0; i < TIL; i++)
         chk($sformatf("%s row%0d", tag, i), 32'(coef[i]), 32'(exp_c[i]));
   endtask

   task automatic finish_out(input string tag);
      rdy = 1'b1;
      tick;
      rdy = 1'b0;
      chk({tag, " idle ready"}, 32'(o_rdy), 32'd1);
      chk({tag, " vld low"}, 32'(o_vld), 32'd0);
      chk({tag, " busy low"}, 32'(o_busy), 32'd0);
   endtask

   task automatic run(input string tag);
      start_tile(tag);
      wait_out(tag);
      check_coefs(tag);
      finish_out(tag);
   endtask

   initial begin
      for (int i = 0; i < TIL; i++) begin
         li_old[i] = '0;
         li_new[i] = '0;
         mi_old[i] = '0;
         mi_new[i] = '0;
      end

      repeat (3) tick;
      chk("reset vld", 32'(o_vld), 32'd0);
      chk("reset busy", 32'(o_busy), 32'd0);
      chk("reset rdy", 32'(o_rdy), 32'd0);
      chk("reset coef0", 32'(coef[0]), 32'd0);
      chk("reset coef15", 32'(coef[TIL-1]), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rdy after reset", 32'(o_rdy), 32'd1);

      t_mode = 1'b0;
      set_all(16'h2000, 16'h4000, 16'h0000, 16'h0000);
      run("rescale");

      t_mode = 1'b1;
      set_all(16'h1111, 16'h4000, 16'h0100, 16'h0300);
      t_ln[5] = 16'h1000;
      run("norm");

      t_mode = 1'b0;
      set_all(16'h2000, 16'h4000, 16'h0000, 16'h0000);
      t_ln[3] = 16'h0000;
      t_lo[7] = 16'h7FFF;
      t_ln[7] = 16'h0001;
      run("divzero");

      t_mode = 1'b0;
      set_all(16'h1234, 16'h1234, 16'h2000, 16'h0000);
      run("clamp");

      for (int k = 0; k < 6; k++) begin
         rand_tile();
         run($sformatf("rand%0d", k));
      end

      rand_tile();
      start_tile("bp");
      wait_out("bp");
      for (int c = 0; c < 10; c++) begin
         vld = 1'b1;
         for (int i = 0; i < TIL; i++) li_new[i] = 16'($urandom);
         tick;
         chk($sformatf("bp vld c%0d", c), 32'(o_vld), 32'd1);
         chk($sformatf("bp rdy c%0d", c), 32'(o_rdy), 32'd0);
         check_coefs($sformatf("bp c%0d", c));
      end
      vld = 1'b0;
      finish_out("bp");

      rand_tile();
      start_tile("midrst");
      repeat (40) tick;
      chk("midrst busy", 32'(o_busy), 32'd1);
      rst_n = 1'b0;
      tick;
      chk("midrst vld", 32'(o_vld), 32'd0);
      chk("midrst busy low", 32'(o_busy), 32'd0);
      chk("midrst rdy in reset", 32'(o_rdy), 32'd0);
      for (int i = 0; i < TIL; i++)
         chk($sformatf("midrst coef%0d", i), 32'(coef[i]), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("midrst rdy released", 32'(o_rdy), 32'd1);
      rand_tile();
      run("post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
